// File: rtl/safety_current_monitor.sv
// Per-axis over-current monitor: one sample strobe starts a 4-axis time-multiplexed scan.
// An axis that is out of tolerance LIMIT consecutive times latches safety_amp_disable_o.
// Latency: axis n (0..3) result registered 3*(n+1) edges after the strobe edge.
// Backpressure: none; a strobe during a scan is dropped and flags overrun_o.
// Ports:
//   sysclk_i, reset_i (async, active-high)
//   sample_strobe_i, cur_cmd_i/cur_fb_i (4 x 16b offset-binary)
//   amp_disable_i (masks counting), amp_enable_cmd_i (clears latch/counter/overrun)
//   safety_amp_disable_o, busy_o, overrun_o, err_count_o (4 x 8b debug counters)
module safety_current_monitor #(
  parameter logic [15:0] TOL       = 16'h0800,
  parameter logic [7:0]  LIMIT     = 8'd40,
  parameter int          CNT_WIDTH = 8
) (
  input  logic        sysclk_i,
  input  logic        reset_i,
  input  logic        sample_strobe_i,
  input  logic [63:0] cur_cmd_i,
  input  logic [63:0] cur_fb_i,
  input  logic [3:0]  amp_disable_i,
  input  logic [3:0]  amp_enable_cmd_i,
  output logic [3:0]  safety_amp_disable_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic [31:0] err_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIFF, S_CMP, S_UPD} state_t;

  localparam logic [CNT_WIDTH:0] LIM_X = (CNT_WIDTH+1)'(LIMIT);

  state_t                 state_q, state_d;
  logic [1:0]             ax_q, ax_d;
  logic [63:0]            cmd_q, cmd_d;
  logic [63:0]            fb_q, fb_d;
  logic [16:0]            diff_q, diff_d;
  logic                   exceed_q, exceed_d;
  logic [CNT_WIDTH-1:0]   cnt_q [4];
  logic [CNT_WIDTH-1:0]   cnt_d [4];
  logic [3:0]             flt_q, flt_d;
  logic                   ovr_q, ovr_d;

  logic [15:0]            cmd_sel, fb_sel;
  logic [16:0]            absd;
  logic [CNT_WIDTH:0]     cnt_inc;

  assign cmd_sel = cmd_q[{ax_q, 4'b0000} +: 16];
  assign fb_sel  = fb_q[{ax_q, 4'b0000} +: 16];

  always_comb begin
    state_d  = state_q;
    ax_d     = ax_q;
    cmd_d    = cmd_q;
    fb_d     = fb_q;
    diff_d   = diff_q;
    exceed_d = exceed_q;
    cnt_d    = cnt_q;
    flt_d    = flt_q;
    ovr_d    = ovr_q;
    // Two's-complement magnitude of a 17b difference of 16b values never exceeds 65535.
    absd     = diff_q[16] ? (~diff_q + 17'd1) : diff_q;
    cnt_inc  = {1'b0, cnt_q[ax_q]} + {{CNT_WIDTH{1'b0}}, 1'b1};

    unique case (state_q)
      S_IDLE: begin
        if (sample_strobe_i) begin
          cmd_d   = cur_cmd_i;
          fb_d    = cur_fb_i;
          ax_d    = 2'd0;
          state_d = S_DIFF;
        end
      end
      S_DIFF: begin
        diff_d  = {1'b0, fb_sel} - {1'b0, cmd_sel};
        state_d = S_CMP;
      end
      S_CMP: begin
        exceed_d = (absd > {1'b0, TOL});
        state_d  = S_UPD;
      end
      S_UPD: begin
        if (amp_disable_i[ax_q]) begin
          cnt_d[ax_q] = '0;
        end else if (exceed_q) begin
          // Counter saturates at LIMIT; the latch keeps re-asserting while errors persist.
          if ({1'b0, cnt_q[ax_q]} != LIM_X) cnt_d[ax_q] = cnt_inc[CNT_WIDTH-1:0];
          if (cnt_inc >= LIM_X) flt_d[ax_q] = 1'b1;
        end else begin
          cnt_d[ax_q] = '0;
        end
        if (ax_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          ax_d    = ax_q + 2'd1;
          state_d = S_DIFF;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sample_strobe_i && (state_q != S_IDLE)) ovr_d = 1'b1;

    // Host clear wins over a same-cycle update or overrun set.
    for (int i = 0; i < 4; i++) begin
      if (amp_enable_cmd_i[i]) begin
        cnt_d[i] = '0;
        flt_d[i] = 1'b0;
      end
    end
    if (|amp_enable_cmd_i) ovr_d = 1'b0;
  end

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      ax_q     <= 2'd0;
      cmd_q    <= '0;
      fb_q     <= '0;
      diff_q   <= '0;
      exceed_q <= 1'b0;
      cnt_q    <= '{default: '0};
      flt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ax_q     <= ax_d;
      cmd_q    <= cmd_d;
      fb_q     <= fb_d;
      diff_q   <= diff_d;
      exceed_q <= exceed_d;
      cnt_q    <= cnt_d;
      flt_q    <= flt_d;
      ovr_q    <= ovr_d;
    end
  end

  assign safety_amp_disable_o = flt_q;
  assign busy_o               = (state_q != S_IDLE);
  assign overrun_o            = ovr_q;

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign err_count_o[8*g +: 8] = 8'(cnt_q[g]);
  end

endmodule

// File: tb/tb_safety_current_monitor.sv
module tb_safety_current_monitor;
  localparam int LIMIT = 4;
  localparam int TOL   = 'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [63:0] cmd = '0;
  logic [63:0] fb = '0;
  logic [3:0]  adis = '0;
  logic [3:0]  aen = '0;
  logic [3:0]  fault;
  logic        busy;
  logic        ovr;
  logic [31:0] errc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  safety_current_monitor #(
    .TOL(16'h0800),
    .LIMIT(8'd4),
    .CNT_WIDTH(8)
  ) dut (
    .sysclk_i(clk),
    .reset_i(rst),
    .sample_strobe_i(strobe),
    .cur_cmd_i(cmd),
    .cur_fb_i(fb),
    .amp_disable_i(adis),
    .amp_enable_cmd_i(aen),
    .safety_amp_disable_o(fault),
    .busy_o(busy),
    .overrun_o(ovr),
    .err_count_o(errc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a scan is a timeline; axis a is judged 3*(a+1) edges after its strobe.
  int          m_cnt [4] = '{0, 0, 0, 0};
  logic [3:0]  m_flt = '0;
  bit          m_ov = 1'b0;
  int          m_age = -1;
  logic [15:0] m_cmd [4];
  logic [15:0] m_fb [4];
  bit          was_busy;
  int          ax;
  int          d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_flt = '0;
      m_ov  = 1'b0;
      m_age = -1;
    end else begin
      was_busy = (m_age >= 0);
      if (was_busy) begin
        m_age++;
        if (m_age % 3 == 0) begin
          ax = m_age / 3 - 1;
          d  = int'(m_fb[ax]) - int'(m_cmd[ax]);
          if (d < 0) d = -d;
          if (adis[ax]) m_cnt[ax] = 0;
          else if (d > TOL) begin
            if (m_cnt[ax] < LIMIT) m_cnt[ax]++;
            if (m_cnt[ax] >= LIMIT) m_flt[ax] = 1'b1;
          end else m_cnt[ax] = 0;
        end
        if (m_age == 12) m_age = -1;
      end
      if (strobe) begin
        if (was_busy) m_ov = 1'b1;
        else begin
          for (int i = 0; i < 4; i++) begin
            m_cmd[i] = cmd[16*i +: 16];
            m_fb[i]  = fb[16*i +: 16];
          end
          m_age = 0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (aen[i]) begin
          m_cnt[i] = 0;
          m_flt[i] = 1'b0;
        end
      end
      if (aen != 4'b0000) m_ov = 1'b0;
    end
  end

  logic [31:0] exp_ec;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) exp_ec[8*i +: 8] = 8'(m_cnt[i]);
    chk("model_fault", {28'd0, fault}, {28'd0, m_flt});
    chk("model_busy", {31'd0, busy}, {31'd0, (m_age >= 0)});
    chk("model_overrun", {31'd0, ovr}, {31'd0, m_ov});
    chk("model_err_count", errc, exp_ec);
  end

  task automatic set_ax(input int a, input logic [15:0] c, input logic [15:0] f);
    cmd[16*a +: 16] = c;
    fb[16*a +: 16]  = f;
  endtask

  task automatic all_equal();
    cmd = {4{16'h8000}};
    fb  = {4{16'h8000}};
  endtask

  // Called at a negedge; returns at the negedge after the strobe edge.
  task automatic pulse();
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic scan(input int extra);
    pulse();
    repeat (12 + extra) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t exceeded limit 5000000", $time);
    $fatal(1);
  end

  int exp3 [7] = '{1, 2, 3, 0, 1, 2, 3};
  bit bad3 [7] = '{1, 1, 1, 0, 1, 1, 1};
  logic [15:0] c16, d16;

  initial begin
    all_equal();
    @(negedge clk);
    chk("reset_fault", {28'd0, fault}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err_count", errc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: matched currents never trip
    for (int i = 0; i < 100; i++) scan($urandom_range(1, 4));
    chk("t1_fault", {28'd0, fault}, 32'd0);
    chk("t1_err_count", errc, 32'd0);
    chk("t1_overrun", {31'd0, ovr}, 32'd0);

    // 2: axis 2 trips on the 4th bad sample, exactly at edge t+6
    set_ax(1, 16'h8000, 16'h9000);
    for (int i = 0; i < 3; i++) scan(7);
    pulse();
    repeat (5) @(negedge clk);
    chk("t2_bit2_t5", {31'd0, fault[1]}, 32'd0);
    @(negedge clk);
    chk("t2_bit2_t6", {31'd0, fault[1]}, 32'd1);
    chk("t2_others", {28'd0, fault & 4'b1101}, 32'd0);
    repeat (14) @(negedge clk);
    aen = 4'b0010;
    @(negedge clk);
    aen = 4'b0000;
    chk("t2_clear", {28'd0, fault}, 32'd0);
    set_ax(1, 16'h8000, 16'h8800);
    for (int i = 0; i < 10; i++) scan(2);
    chk("t2_diff_eq_tol", {28'd0, fault}, 32'd0);
    all_equal();

    // 3: only strictly consecutive errors accumulate
    for (int i = 0; i < 7; i++) begin
      set_ax(0, 16'h8000, bad3[i] ? 16'h9000 : 16'h8000);
      pulse();
      repeat (3) @(negedge clk);
      chk("t3_cnt1", {24'd0, errc[7:0]}, 32'(exp3[i]));
      repeat (12) @(negedge clk);
    end
    chk("t3_fault", {28'd0, fault}, 32'd0);
    all_equal();

    // 4: masked axis holds at zero; negative difference trips
    adis = 4'b0100;
    set_ax(2, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 50; i++) scan(1);
    chk("t4_masked_fault", {31'd0, fault[2]}, 32'd0);
    chk("t4_masked_cnt", {24'd0, errc[23:16]}, 32'd0);
    adis = 4'b0000;
    set_ax(2, 16'hFFFF, 16'h0000);
    for (int i = 0; i < LIMIT - 1; i++) scan(1);
    chk("t4_neg_before", {31'd0, fault[2]}, 32'd0);
    chk("t4_neg_cnt", {24'd0, errc[23:16]}, 32'd3);
    scan(1);
    chk("t4_neg_trip", {31'd0, fault[2]}, 32'd1);
    all_equal();

    // 5: clear in the same cycle as axis 2 update wins
    set_ax(1, 16'h8000, 16'h9000);
    for (int i = 0; i < LIMIT; i++) scan(2);
    chk("t5_latched", {31'd0, fault[1]}, 32'd1);
    pulse();
    repeat (5) @(negedge clk);
    aen = 4'b0010;
    @(negedge clk);
    aen = 4'b0000;
    chk("t5_clr_fault", {31'd0, fault[1]}, 32'd0);
    chk("t5_clr_cnt", {24'd0, errc[15:8]}, 32'd0);
    chk("t5_ax3_kept", {31'd0, fault[2]}, 32'd1);
    repeat (10) @(negedge clk);
    all_equal();

    // 6: overrun, its clear, and asynchronous mid-scan reset
    pulse();
    repeat (4) @(negedge clk);
    pulse();
    chk("t6_overrun_set", {31'd0, ovr}, 32'd1);
    repeat (10) @(negedge clk);
    chk("t6_overrun_sticky", {31'd0, ovr}, 32'd1);
    aen = 4'b1000;
    @(negedge clk);
    aen = 4'b0000;
    chk("t6_overrun_clr", {31'd0, ovr}, 32'd0);
    pulse();
    repeat (4) @(negedge clk);
    pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_overrun", {31'd0, ovr}, 32'd0);
    chk("t6_rst_fault", {28'd0, fault}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic: snapshots, overruns, masks and clears all checked by the model
    for (int c = 0; c < 3000; c++) begin
      for (int a = 0; a < 4; a++) begin
        c16 = 16'($urandom);
        d16 = 16'($urandom_range(1792, 2304));
        set_ax(a, c16, ($urandom_range(0, 1) == 0) ? c16 + d16 : c16 - d16);
      end
      strobe = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) adis = 4'($urandom_range(0, 15));
      aen = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      @(negedge clk);
    end
    strobe = 1'b0;
    aen = 4'b0000;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
